nec_ir_rx: RTL

Receive-side decoder for the IrDA/IR link on the 12 MHz iCEstick. It consumes the demodulated receiver output (`RXD` from the IrDA transceiver), measures mark/space widths, and decodes NEC-format frames: 9 ms leader, 4.5 ms space, 32 bits LSB-first, and a stop mark. It also recognises NEC repeat codes (9 ms leader followed by a 2.25 ms space). It is the counterpart of the NEC transmitter stage and delivers each decoded 32-bit word to downstream logic with a one-cycle strobe.

---
 rtl/nec_ir_rx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/nec_ir_rx.sv
// nec_ir_rx: NEC IR frame and repeat-code decoder using mark/space width windows
module nec_ir_rx #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int LEAD_MARK_MIN = 96000,
  parameter int LEAD_MARK_MAX = 120000,
  parameter int LEAD_SPC_MIN  = 48000,
  parameter int LEAD_SPC_MAX  = 60000,
  parameter int RPT_SPC_MIN   = 21000,
  parameter int RPT_SPC_MAX   = 33000,
  parameter int BIT_MARK_MIN  = 3600,
  parameter int BIT_MARK_MAX  = 9600,
  parameter int ZERO_SPC_MIN  = 3600,
  parameter int ZERO_SPC_MAX  = 9600,
  parameter int ONE_SPC_MIN   = 15600,
  parameter int ONE_SPC_MAX   = 24000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic [31:0] data,
  output logic        frame_valid,
  output logic        check_ok,
  output logic        repeat_pulse,
  output logic        err,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic mark_q, mark_d, mark, rise, fall;
  logic [16:0] cnt_q, cnt_d;
  logic [5:0] idx_q, idx_d;
  logic [31:0] sr_q, sr_d, data_q, data_d;
  logic rpt_q, rpt_d, chk_q, chk_d, fv_q, fv_d, rp_q, rp_d, err_q, err_d;
  logic bm_ok, zero, one;
  int wid, tmax;
  function automatic logic in_w(input int w, input int lo, input int hi);
    return w >= lo && w <= hi;
  endfunction
  assign mark  = sync_q[1] ^ ACTIVE_LOW;
  assign rise  = mark & ~mark_q;
  assign fall  = ~mark & mark_q;
  assign wid   = int'({15'd0, cnt_q});
  assign bm_ok = in_w(wid, BIT_MARK_MIN, BIT_MARK_MAX);
  assign zero  = in_w(wid, ZERO_SPC_MIN, ZERO_SPC_MAX);
  assign one   = in_w(wid, ONE_SPC_MIN, ONE_SPC_MAX);
  assign tmax  = state_q == LEAD_MARK  ? LEAD_MARK_MAX :
                 state_q == LEAD_SPACE ? LEAD_SPC_MAX  :
                 state_q == BIT_SPACE  ? ONE_SPC_MAX   : BIT_MARK_MAX;
  assign data         = data_q;
  assign frame_valid  = fv_q;
  assign check_ok     = chk_q;
  assign repeat_pulse = rp_q;
  assign err          = err_q;
  assign busy         = state_q != IDLE;
  // Width measurement and frame decoding; a timeout wins over a coincident edge
  always_comb begin
    sync_d  = {sync_q[0], rxd};
    mark_d  = mark;
    cnt_d   = (rise | fall) ? 17'd1 : (&cnt_q ? cnt_q : cnt_q + 17'd1);
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    rpt_d   = rpt_q;
    data_d  = data_q;
    chk_d   = chk_q;
    fv_d    = 1'b0;
    rp_d    = 1'b0;
    err_d   = 1'b0;
    if (state_q != IDLE && wid > tmax) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (rise) begin
          state_d = LEAD_MARK;
          rpt_d   = 1'b0;
        end
        LEAD_MARK: if (fall) state_d = in_w(wid, LEAD_MARK_MIN, LEAD_MARK_MAX) ? LEAD_SPACE : IDLE;
        LEAD_SPACE: if (rise) begin
          if (in_w(wid, LEAD_SPC_MIN, LEAD_SPC_MAX)) begin
            idx_d   = 6'd0;
            state_d = BIT_MARK;
          end else if (in_w(wid, RPT_SPC_MIN, RPT_SPC_MAX)) begin
            rpt_d   = 1'b1;
            state_d = STOP_MARK;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        BIT_MARK: if (fall) begin
          state_d = bm_ok ? BIT_SPACE : IDLE;
          err_d   = ~bm_ok;
        end
        BIT_SPACE: if (rise) begin
          if (zero | one) begin
            sr_d    = {one, sr_q[31:1]};
            idx_d   = idx_q + 6'd1;
            state_d = idx_q == 6'd31 ? STOP_MARK : BIT_MARK;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        STOP_MARK: if (fall) begin
          state_d = IDLE;
          err_d   = ~bm_ok;
          rp_d    = bm_ok & rpt_q;
          fv_d    = bm_ok & ~rpt_q;
          data_d  = (bm_ok & ~rpt_q) ? sr_q : data_q;
          chk_d   = (bm_ok & ~rpt_q) ? ((sr_q[7:0] ^ sr_q[15:8]) == 8'hFF) && ((sr_q[23:16] ^ sr_q[31:24]) == 8'hFF) : chk_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // State and datapath registers; the synchronizer resets to the idle (space) level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= {2{ACTIVE_LOW}};
      mark_q  <= 1'b0;
      cnt_q   <= 17'd0;
      state_q <= IDLE;
      idx_q   <= 6'd0;
      sr_q    <= 32'd0;
      rpt_q   <= 1'b0;
      data_q  <= 32'd0;
      chk_q   <= 1'b0;
      fv_q    <= 1'b0;
      rp_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      mark_q  <= mark_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      rpt_q   <= rpt_d;
      data_q  <= data_d;
      chk_q   <= chk_d;
      fv_q    <= fv_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
    end
endmodule
